// File: rtl/rf_wport_arbiter_pkg.sv
// Shared widths, bus field offsets and the write-entry layout for the
// register-file write-port arbiter.
package rf_wport_arbiter_pkg;

  localparam int WB_RF_BUS_W = 38;
  localparam int DIV_BUS_W   = 69;
  localparam int TO_ID_BUS_W = 6;

  localparam int WB_GR_WE_BIT = 37;
  localparam int WB_DEST_LSB  = 32;
  localparam int WB_WDATA_LSB = 0;

  localparam int DIV_DEST_LSB  = 64;
  localparam int DIV_WDATA_LSB = 32;
  localparam int DIV_PC_LSB    = 0;

  // The field order matches div_bus, so the bus casts straight into an entry.
  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] wdata;
    logic [31:0] pc;
  } rf_wentry_t;

endpackage

// File: rtl/rf_wbuf.sv
// One-entry valid/ready holding buffer for divider results waiting on the
// register-file write port.
module rf_wbuf
  import rf_wport_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  rf_wentry_t in_entry,
  input  logic       clear,
  output logic       buf_valid,
  output rf_wentry_t buf_entry
);

  // Ready only when empty, so an entry can be taken at the earliest in the
  // cycle after a drain.
  assign in_ready = ~buf_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_entry <= '0;
    end else if (in_valid && in_ready) begin
      buf_valid <= 1'b1;
      buf_entry <= in_entry;
    end else if (clear) begin
      buf_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Arbitrates the single regfile write port between WB retirement and buffered
// divider results; WB wins unless the buffer has been starved too long.
module rf_wport_arbiter
  import rf_wport_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_validout,
  input  logic [WB_RF_BUS_W-1:0] wb_regfile_bus,
  input  logic [31:0]            wb_pc,
  output logic                   wb_other_allowin,
  input  logic                   div_valid,
  output logic                   div_ready,
  input  logic [DIV_BUS_W-1:0]   div_bus,
  output logic                   rf_we,
  output logic [4:0]             rf_waddr,
  output logic [31:0]            rf_wdata,
  output logic [TO_ID_BUS_W-1:0] pend_to_id_bus,
  output logic [31:0]            debug_wb_pc,
  output logic [3:0]             debug_wb_rf_we,
  output logic [4:0]             debug_wb_rf_wnum,
  output logic [31:0]            debug_wb_rf_wdata
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic        wb_gr_we;
  logic [4:0]  wb_dest;
  logic [31:0] wb_wdata;
  logic        buf_valid;
  rf_wentry_t  buf_entry;
  logic [CNT_W-1:0] starve_cnt;
  logic        force_buf;
  logic        wb_wr;
  logic        grant_buf;

  assign wb_gr_we = wb_regfile_bus[WB_GR_WE_BIT];
  assign wb_dest  = wb_regfile_bus[WB_DEST_LSB +: 5];
  assign wb_wdata = wb_regfile_bus[WB_WDATA_LSB +: 32];

  rf_wbuf u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (div_valid),
    .in_ready  (div_ready),
    .in_entry  (rf_wentry_t'(div_bus)),
    .clear     (grant_buf),
    .buf_valid (buf_valid),
    .buf_entry (buf_entry)
  );

  // Decoded purely from registers so WB's allowin has no path from WB inputs.
  assign force_buf = buf_valid && (starve_cnt >= LIMIT);
  assign wb_wr     = wb_validout & wb_gr_we & ~force_buf;
  assign grant_buf = buf_valid & (force_buf | ~(wb_validout & wb_gr_we));
  assign wb_other_allowin = ~force_buf;

  always_ff @(posedge clk) begin
    if (rst || grant_buf || !buf_valid) begin
      starve_cnt <= '0;
    end else if (starve_cnt < LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_comb begin
    rf_we       = 1'b0;
    rf_waddr    = wb_dest;
    rf_wdata    = wb_wdata;
    debug_wb_pc = wb_pc;
    if (wb_wr) begin
      rf_we = ~rst;
    end else if (grant_buf) begin
      rf_we       = ~rst;
      rf_waddr    = buf_entry.dest;
      rf_wdata    = buf_entry.wdata;
      debug_wb_pc = buf_entry.pc;
    end
  end

  assign pend_to_id_bus    = {buf_valid, buf_entry.dest & {5{buf_valid}}};
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Scenario bench for rf_wport_arbiter: every regfile write is matched against
// an expected queue filled as stimulus is driven.
module tb_rf_wport_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_validout;
  logic [37:0] wb_regfile_bus;
  logic [31:0] wb_pc;
  logic        wb_other_allowin;
  logic        div_valid;
  logic        div_ready;
  logic [68:0] div_bus;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [5:0]  pend_to_id_bus;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int errors = 0;
  int checks = 0;
  logic [68:0] exp_q[$];
  logic [68:0] mon_exp;

  rf_wport_arbiter dut (
    .clk               (clk),
    .rst               (rst),
    .wb_validout       (wb_validout),
    .wb_regfile_bus    (wb_regfile_bus),
    .wb_pc             (wb_pc),
    .wb_other_allowin  (wb_other_allowin),
    .div_valid         (div_valid),
    .div_ready         (div_ready),
    .div_bus           (div_bus),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .pend_to_id_bus    (pend_to_id_bus),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic v, input logic we, input logic [4:0] d,
                        input logic [31:0] w, input logic [31:0] pc);
    wb_validout    = v;
    wb_regfile_bus = {we, d, w};
    wb_pc          = pc;
  endtask

  task automatic set_div(input logic v, input logic [4:0] d,
                         input logic [31:0] w, input logic [31:0] pc);
    div_valid = v;
    div_bus   = {d, w, pc};
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    checks++;
    if ((dut.wb_wr & dut.grant_buf) !== 1'b0) begin
      errors++;
      $display("FAIL mutex: wb_wr=%b grant_buf=%b both set", dut.wb_wr, dut.grant_buf);
    end
    if (rf_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: waddr=%0d wdata=%h pc=%h, expected no write",
                 rf_waddr, rf_wdata, debug_wb_pc);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({rf_waddr, rf_wdata, debug_wb_pc} !== mon_exp) begin
          errors++;
          $display("FAIL write: got dest=%0d wdata=%h pc=%h, expected dest=%0d wdata=%h pc=%h",
                   rf_waddr, rf_wdata, debug_wb_pc, mon_exp[68:64], mon_exp[63:32], mon_exp[31:0]);
        end
        checks++;
        if ({debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata} !== {4'hf, mon_exp[68:32]}) begin
          errors++;
          $display("FAIL debug_trace: got we=%h wnum=%0d wdata=%h, expected we=f wnum=%0d wdata=%h",
                   debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata, mon_exp[68:64], mon_exp[63:32]);
        end
      end
    end else begin
      checks++;
      if (rf_we !== 1'b0 || debug_wb_rf_we !== 4'h0) begin
        errors++;
        $display("FAIL idle_we: rf_we=%b debug_we=%h, expected 0/0", rf_we, debug_wb_rf_we);
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    set_wb(1'b1, 1'b1, 5'd4, 32'hdead_beef, 32'h1c00_0000);
    set_div(1'b1, 5'd6, 32'h0000_0055, 32'h1c00_0010);
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({div_ready, wb_other_allowin, pend_to_id_bus} !== {1'b1, 1'b1, 6'd0}) begin
        errors++;
        $display("FAIL reset_outputs: ready=%b allowin=%b pend=%h, expected 1 1 00",
                 div_ready, wb_other_allowin, pend_to_id_bus);
      end
      step();
    end
    rst = 1'b0;
    set_wb(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    set_div(1'b0, 5'd0, 32'd0, 32'd0);
    @(negedge clk);
    checks++;
    if ({div_ready, pend_to_id_bus} !== {1'b1, 6'd0}) begin
      errors++;
      $display("FAIL reset_no_capture: ready=%b pend=%h, expected 1 00", div_ready, pend_to_id_bus);
    end
    step();
  endtask

  task automatic test_idle_drain();
    set_div(1'b1, 5'd5, 32'h0000_1234, 32'h1c00_0040);
    @(negedge clk);
    checks++;
    if (div_ready !== 1'b1) begin
      errors++;
      $display("FAIL drain_ready0: got %b expected 1", div_ready);
    end
    step();
    set_div(1'b0, 5'd0, 32'd0, 32'd0);
    exp_q.push_back({5'd5, 32'h0000_1234, 32'h1c00_0040});
    @(negedge clk);
    checks++;
    if ({div_ready, pend_to_id_bus} !== {1'b0, 1'b1, 5'd5}) begin
      errors++;
      $display("FAIL drain_cycle1: ready=%b pend=%h, expected 0 25", div_ready, pend_to_id_bus);
    end
    step();
    @(negedge clk);
    checks++;
    if ({div_ready, pend_to_id_bus} !== {1'b1, 6'd0}) begin
      errors++;
      $display("FAIL drain_cycle2: ready=%b pend=%h, expected 1 00", div_ready, pend_to_id_bus);
    end
    step();
  endtask

  task automatic test_wb_priority();
    logic [31:0] bw, w;
    bw = $urandom;
    set_div(1'b1, 5'd9, bw, 32'h1c00_0100);
    step();
    set_div(1'b0, 5'd0, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      set_wb(1'b1, 1'b1, 5'd3, w, 32'h1c00_0200 + 32'(4 * i));
      exp_q.push_back({5'd3, w, 32'h1c00_0200 + 32'(4 * i)});
      @(negedge clk);
      checks++;
      if ({wb_other_allowin, pend_to_id_bus} !== {1'b1, 1'b1, 5'd9}) begin
        errors++;
        $display("FAIL prio_hold[%0d]: allowin=%b pend=%h, expected 1 29", i, wb_other_allowin, pend_to_id_bus);
      end
      step();
    end
    set_wb(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    exp_q.push_back({5'd9, bw, 32'h1c00_0100});
    step();
  endtask

  task automatic test_starvation();
    logic [4:0]  d, hd;
    logic [31:0] w, hw;
    d = 5'($urandom_range(1, 31));
    w = $urandom;
    set_div(1'b1, 5'd7, 32'h7777_0007, 32'h1c00_0300);
    set_wb(1'b1, 1'b1, d, w, 32'h1c00_0400);
    exp_q.push_back({d, w, 32'h1c00_0400});
    step();
    set_div(1'b0, 5'd0, 32'd0, 32'd0);
    for (int c = 1; c <= 4; c++) begin
      d = 5'($urandom_range(1, 31));
      w = $urandom;
      set_wb(1'b1, 1'b1, d, w, 32'h1c00_0400 + 32'(4 * c));
      exp_q.push_back({d, w, 32'h1c00_0400 + 32'(4 * c)});
      @(negedge clk);
      checks++;
      if (wb_other_allowin !== 1'b1) begin
        errors++;
        $display("FAIL starve_denied[%0d]: allowin=%b expected 1", c, wb_other_allowin);
      end
      step();
    end
    hd = 5'd21;
    hw = $urandom;
    set_wb(1'b1, 1'b1, hd, hw, 32'h1c00_0500);
    exp_q.push_back({5'd7, 32'h7777_0007, 32'h1c00_0300});
    @(negedge clk);
    checks++;
    if ({wb_other_allowin, pend_to_id_bus} !== {1'b0, 1'b1, 5'd7}) begin
      errors++;
      $display("FAIL starve_force: allowin=%b pend=%h, expected 0 27", wb_other_allowin, pend_to_id_bus);
    end
    step();
    exp_q.push_back({hd, hw, 32'h1c00_0500});
    @(negedge clk);
    checks++;
    if ({wb_other_allowin, pend_to_id_bus} !== {1'b1, 6'd0}) begin
      errors++;
      $display("FAIL starve_release: allowin=%b pend=%h, expected 1 00", wb_other_allowin, pend_to_id_bus);
    end
    step();
    set_wb(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
  endtask

  task automatic test_shared_cycle();
    set_div(1'b1, 5'd11, 32'h0b0b_0b0b, 32'h1c00_0600);
    step();
    set_div(1'b0, 5'd0, 32'd0, 32'd0);
    set_wb(1'b1, 1'b0, 5'd2, 32'h0000_ffff, 32'h1c00_0700);
    exp_q.push_back({5'd11, 32'h0b0b_0b0b, 32'h1c00_0600});
    @(negedge clk);
    checks++;
    if (wb_other_allowin !== 1'b1) begin
      errors++;
      $display("FAIL shared_allowin: got %b expected 1", wb_other_allowin);
    end
    step();
    set_wb(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    @(negedge clk);
    checks++;
    if (pend_to_id_bus !== 6'd0) begin
      errors++;
      $display("FAIL shared_pend: got %h expected 00", pend_to_id_bus);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    set_div(1'b1, 5'd12, 32'haaaa_0001, 32'h1c00_0800);
    step();
    set_div(1'b1, 5'd14, 32'hbbbb_0002, 32'h1c00_0804);
    for (int c = 1; c <= 3; c++) begin
      if (c < 3) begin
        w = $urandom;
        set_wb(1'b1, 1'b1, 5'd1, w, 32'h1c00_0900 + 32'(4 * c));
        exp_q.push_back({5'd1, w, 32'h1c00_0900 + 32'(4 * c)});
      end else begin
        set_wb(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        exp_q.push_back({5'd12, 32'haaaa_0001, 32'h1c00_0800});
      end
      @(negedge clk);
      checks++;
      if (div_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_blocked[%0d]: ready=%b expected 0", c, div_ready);
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (div_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: ready=%b expected 1", div_ready);
    end
    step();
    set_div(1'b0, 5'd0, 32'd0, 32'd0);
    exp_q.push_back({5'd14, 32'hbbbb_0002, 32'h1c00_0804});
    step();
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    w = $urandom;
    set_div(1'b1, 5'd13, 32'hcccc_0003, 32'h1c00_0a00);
    step();
    set_div(1'b0, 5'd0, 32'd0, 32'd0);
    set_wb(1'b1, 1'b1, 5'd8, w, 32'h1c00_0b00);
    exp_q.push_back({5'd8, w, 32'h1c00_0b00});
    step();
    rst = 1'b1;
    set_wb(1'b1, 1'b1, 5'd8, 32'h1111_1111, 32'h1c00_0b04);
    step();
    rst = 1'b0;
    set_wb(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    @(negedge clk);
    checks++;
    if ({div_ready, pend_to_id_bus} !== {1'b1, 6'd0}) begin
      errors++;
      $display("FAIL reset_mid_discard: ready=%b pend=%h, expected 1 00", div_ready, pend_to_id_bus);
    end
    step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    set_wb(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    set_div(1'b0, 5'd0, 32'd0, 32'd0);
    test_reset();
    test_idle_drain();
    test_wb_priority();
    test_starvation();
    test_shared_cycle();
    test_back_to_back();
    test_reset_mid();
    repeat (2) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drained: %0d writes still expected, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
